// File: rtl/mul_4b_seq.sv
// 4x4 -> 8 unsigned sequential shift-add multiplier (IDLE/CALC/DONE), one adder
// iteration per clock. Optional macro MUL_ZERO_BYPASS_EN: zero operands finish in one cycle.

module fa_1b (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// Structural 4-bit ripple-carry adder built from fa_1b cells.
module rca_4b (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [4:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      fa_1b u_fa (
         .a   (a[i]),
         .b   (b[i]),
         .cin (c[i]),
         .s   (s[i]),
         .cout(c[i+1])
      );
   end

   assign cout = c[4];
endmodule

module mul_4b_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic       busy,
   output logic       done,
   output logic [7:0] P
);
   // Valid/ready contract: start is taken only in IDLE (busy=0) at a rising edge;
   // done pulses for one cycle with P already holding the new product.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] mcand;
   logic [7:0] partial;
   logic [1:0] cnt;
   logic [7:0] p_q;

   logic [3:0] add_b;
   logic [3:0] add_s;
   logic       add_co;
   logic [7:0] partial_nxt;

   logic       accept;
   logic       iterate;
   logic       load_p;
   logic       bypass_hit;

`ifdef MUL_ZERO_BYPASS_EN
   assign bypass_hit = (A == 4'd0) || (B == 4'd0);
`else
   assign bypass_hit = 1'b0;
`endif

   // Adding zero when partial[0]=0 yields {0, partial[7:4]}, so one adder serves both cases.
   assign add_b       = partial[0] ? mcand : 4'd0;
   assign partial_nxt = {add_co, add_s, partial[3:1]};

   rca_4b u_add (
      .a   (partial[7:4]),
      .b   (add_b),
      .cin (1'b0),
      .s   (add_s),
      .cout(add_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      iterate   = 1'b0;
      load_p    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = bypass_hit ? DONE : CALC;
            end
         end
         CALC: begin
            iterate = 1'b1;
            if (cnt == 2'd3) begin
               load_p    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= 4'd0;
         partial <= 8'd0;
         cnt     <= 2'd0;
         p_q     <= 8'd0;
      end else begin
         if (accept) begin
            mcand   <= A;
            partial <= {4'd0, B};
            cnt     <= 2'd0;
            if (bypass_hit) begin
               p_q <= 8'd0;
            end
         end
         if (iterate) begin
            partial <= partial_nxt;
            cnt     <= cnt + 2'd1;
         end
         // P is only updated with the finished product, never with intermediates.
         if (load_p) begin
            p_q <= partial_nxt;
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign P    = p_q;

endmodule

// File: tb/tb_mul_4b_seq.sv
// Self-checking bench for mul_4b_seq: directed vectors, expected products queued
// on accept and compared by a monitor on each done pulse.

module tb_mul_4b_seq;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic       busy;
   logic       done;
   logic [7:0] P;

   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   int         checks   = 0;
   int         errors   = 0;
   int         done_cnt = 0;
   int         push_cnt = 0;
   int         bc;

`ifdef MUL_ZERO_BYPASS_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 5;
`endif

   always #5 clk = ~clk;

   mul_4b_seq dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .A    (A),
      .B    (B),
      .busy (busy),
      .done (done),
      .P    (P)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse consumes one expected product.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got P=0x%0h expected no done", P);
         end else begin
            mon_exp = exp_q.pop_front();
            if (P !== mon_exp) begin
               errors++;
               $display("FAIL product: got P=0x%0h expected 0x%0h", P, mon_exp);
            end
         end
      end
   end

   // Drive an accepted start; returns #1 after the accept edge.
   task automatic start_op(input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] prod, input bit keep_start);
      A     = a;
      B     = b;
      start = 1'b1;
      exp_q.push_back(prod);
      push_cnt++;
      @(posedge clk);
      #1;
      if (!keep_start) start = 1'b0;
   endtask

   // Waits (bounded) for done, checks latency in cycles after accept, then
   // steps one more edge so the block is back in IDLE.
   task automatic wait_done(input string name, input int exp_lat, input bit chk_hold,
                            input logic [7:0] hold, output int busy_cycles);
      int lat;
      lat         = 1;
      busy_cycles = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) busy_cycles++;
         if (chk_hold) check({name, "_p_hold"}, P, hold);
         @(posedge clk);
         #1;
         lat++;
      end
      if (done !== 1'b1) begin
         check({name, "_timeout"}, 0, 1);
      end else begin
         if (busy === 1'b1) busy_cycles++;
         check({name, "_latency"}, lat, exp_lat);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      A     = 4'd0;
      B     = 4'd0;
      #3;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_p", P, 8'h00);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 3 x 5: latency and busy width
      start_op(4'd3, 4'd5, 8'h0F, 1'b0);
      wait_done("mul_3x5", 5, 1'b0, 8'h00, bc);
      check("mul_3x5_busy_cycles", bc, 5);
      check("mul_3x5_idle_busy", busy, 0);

      // 15 x 15 then 1 x 1, P holds 0xE1 meanwhile
      start_op(4'd15, 4'd15, 8'hE1, 1'b0);
      wait_done("mul_15x15", 5, 1'b0, 8'h00, bc);
      start_op(4'd1, 4'd1, 8'h01, 1'b0);
      wait_done("mul_1x1", 5, 1'b1, 8'hE1, bc);
      check("mul_1x1_p_after", P, 8'h01);

      // zero operand
      start_op(4'd9, 4'd0, 8'h00, 1'b0);
      wait_done("mul_9x0", ZERO_LAT, 1'b0, 8'h00, bc);

      // 7 x 6 with start held and operands changing while busy
      start_op(4'd7, 4'd6, 8'h2A, 1'b1);
      A = 4'd2;
      B = 4'd2;
      wait_done("mul_7x6", 5, 1'b0, 8'h00, bc);
      start = 1'b0;
      check("mul_7x6_p_after", P, 8'h2A);
      repeat (3) @(posedge clk);
      #1;
      check("mul_7x6_no_restart", busy, 0);

      // reset during the 2nd CALC cycle
      A     = 4'd12;
      B     = 4'd11;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_p", P, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("abort_p_after", P, 8'h00);
      check("abort_busy_after", busy, 0);

      // first start after reset is accepted normally
      start_op(4'd2, 4'd3, 8'h06, 1'b0);
      wait_done("mul_after_reset", 5, 1'b0, 8'h00, bc);

      // exhaustive back-to-back sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            start_op(4'(a), 4'(b), 8'(a * b), 1'b0);
            wait_done("sweep", (a == 0 || b == 0) ? ZERO_LAT : 5, 1'b0, 8'h00, bc);
         end
      end

      repeat (3) @(posedge clk);
      #1;
      check("done_count", done_cnt, push_cnt);
      check("exp_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
